regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised next-generation register file for the RISC-V core: two read ports and one write port.
- Adds asynchronous reset clearing, optional hardwired-zero register x0, and write-to-read bypass.
- Adds an optional registered-read mode, and a per-register pending (scoreboard) bit so the issue stage can detect RAW hazards.
- Sits between decode/issue (reads, pending marks) and writeback (writes).

Parameters:
DATA_W, 32, width of each register and of data ports
ADDR_W, 5, register index width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads and ready flags
REG_OUT, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
reg_write  input  1  write enable
write_reg  input  ADDR_W  write index
write_data  input  DATA_W  write data
read_reg1  input  ADDR_W  read port 1 index
read_reg2  input  ADDR_W  read port 2 index
read_data1  output  DATA_W  read port 1 data
read_data2  output  DATA_W  read port 2 data
mark_valid  input  1  issue: mark mark_reg as pending
mark_reg  input  ADDR_W  destination index being issued
read_ready1  output  1  operand 1 has no outstanding producer
read_ready2  output  1  operand 2 has no outstanding producer

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0; all pending bits 0. With REG_OUT=1, read_data1/2 are 0. Reset takes effect immediately, even mid-write; the write is lost.
- Write: on the rising edge, if reg_write, regs[write_reg] <= write_data. With ZERO_REG=1 and write_reg==0, the write is ignored.
- Raw read value: regs[read_regN], or 0 if ZERO_REG=1 and read_regN==0.
- Bypass (BYPASS=1): if reg_write && write_reg==read_regN && !(ZERO_REG && read_regN==0), the effective value is write_data. Otherwise the effective value is the raw read value.
- REG_OUT=0: read_dataN = effective value, combinational.
- REG_OUT=1: read_dataN is sampled at the rising edge from the effective value, using the index present before the edge. Latency is 1 cycle.
- Bypass with BYPASS=0: in combinational mode, the old value is seen in the write cycle and the new value after the edge.
- Pending set: on the rising edge, if mark_valid, pending[mark_reg] <= 1. Ignored for index 0 when ZERO_REG=1.
- Pending clear: on the rising edge, if reg_write, pending[write_reg] <= 0.
- Simultaneous set and clear of the same index: set wins; a new producer has been issued.
- Different indices are set and cleared independently in the same cycle.
- read_readyN (combinational) = !pending[read_regN] || (BYPASS && reg_write && write_reg==read_regN). Always 1 for index 0 when ZERO_REG=1.
- Both read ports are fully independent; the same index on both ports returns identical data and ready flags.
- All index arithmetic is unsigned ADDR_W bits; no out-of-range indices exist.

Test Plan:
- Reset, then write 2022 to x7 with reg_write=1 for one cycle; then read_reg1=7, read_reg2=23 -> read_data1=2022, read_data2=0.
- ZERO_REG=1: write 0xDEADBEEF to x0; read_reg1=0 -> read_data1=0, read_ready1=1; mark_valid with mark_reg=0 -> read_ready1 stays 1.
- BYPASS=1, REG_OUT=0: x17 holds 2022; same cycle reg_write=1, write_reg=17, write_data=2023, read_reg2=17 -> read_data2=2023 before the edge. With BYPASS=0 -> 2022 before the edge, 2023 after.
- Scoreboard: mark_valid, mark_reg=10 -> next cycle read_reg1=10 gives read_ready1=0; write x10=55 -> read_ready1=1 in the write cycle (bypass) and stays 1 after. Simultaneous mark and write to x10 -> pending remains 1.
- REG_OUT=1: x5=99; set read_reg1=5 at cycle n -> read_data1=99 at cycle n+1, not before; outputs 0 immediately on rst_n low.
- Async reset mid-operation: write x3=7; assert rst_n low between edges with reg_write=1 -> x3 reads 0 and all read_ready=1 immediately, with no clock edge needed.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with two read ports and one write port, plus a per-register pending
// bit that the issue stage uses to detect RAW hazards. Optional hardwired x0,
// write-to-read bypass and registered read outputs.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          REG_OUT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              mark_valid,
    input  logic [ADDR_W-1:0] mark_reg,
    output logic              read_ready1,
    output logic              read_ready2
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  pending_d;

    logic              wr_en;
    logic              mark_en;
    logic [ADDR_W-1:0] rd_idx   [2];
    logic [DATA_W-1:0] rd_eff   [2];
    logic              rd_ready [2];

    // x0 absorbs writes and never becomes pending when hardwired
    assign wr_en   = reg_write && !(ZERO_REG && (write_reg == '0));
    assign mark_en = mark_valid && !(ZERO_REG && (mark_reg == '0));

    assign rd_idx[0] = read_reg1;
    assign rd_idx[1] = read_reg2;

    // Register array storage; reset clears every entry and drops any in-flight write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[write_reg] <= write_data;
        end
    end

    // Pending next state: writeback clears, issue sets; set is applied last so it wins
    always_comb begin
        pending_d = pending_q;
        if (reg_write) begin
            pending_d[write_reg] = 1'b0;
        end
        if (mark_en) begin
            pending_d[mark_reg] = 1'b1;
        end
    end

    // Pending bit storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Effective read value and operand-ready flag per port, including same-cycle bypass
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic zero_hit;
            logic byp_hit;
            zero_hit    = ZERO_REG && (rd_idx[p] == '0);
            byp_hit     = BYPASS && reg_write && (write_reg == rd_idx[p]) && !zero_hit;
            rd_eff[p]   = zero_hit ? '0 : (byp_hit ? write_data : regs_q[rd_idx[p]]);
            rd_ready[p] = zero_hit || !pending_q[rd_idx[p]] || byp_hit;
        end
    end

    assign read_ready1 = rd_ready[0];
    assign read_ready2 = rd_ready[1];

    if (REG_OUT) begin : g_reg_out
        logic [DATA_W-1:0] rdata_q [2];

        // Registered read: capture the effective value seen before the edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q[0] <= '0;
                rdata_q[1] <= '0;
            end else begin
                rdata_q[0] <= rd_eff[0];
                rdata_q[1] <= rd_eff[1];
            end
        end

        assign read_data1 = rdata_q[0];
        assign read_data2 = rdata_q[1];
    end else begin : g_comb_out
        assign read_data1 = rd_eff[0];
        assign read_data2 = rd_eff[1];
    end

endmodule
